// File: rtl/hazard_scoreboard_if.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_if
// Purpose : bundles the DE-stage instruction fields and the hazard-unit
//           responses exchanged between the pipeline and hazard_scoreboard.
// Ports   : master - pipeline side; drives the DE fields and branch_taken_ex,
//                    receives stall_fd / clr / flush_fd / busy_vec / stall_cnt.
//           slave  - hazard unit side; the reverse directions.
// ---------------------------------------------------------------------------
interface hazard_scoreboard_if #(
  parameter int REG_W  = 5,
  parameter int PERF_W = 16
);
  localparam int NREGS = 2**REG_W;

  logic              valid_de;
  logic [REG_W-1:0]  rs1_de;
  logic [REG_W-1:0]  rs2_de;
  logic              rs1_use_de;
  logic              rs2_use_de;
  logic [REG_W-1:0]  rd_de;
  logic              RFwr_de;
  logic              DMrd_de;
  logic              branch_taken_ex;
  logic              stall_fd;
  logic              clr;
  logic              flush_fd;
  logic [NREGS-1:0]  busy_vec;
  logic [PERF_W-1:0] stall_cnt;

  modport master (
    output valid_de, rs1_de, rs2_de, rs1_use_de, rs2_use_de,
           rd_de, RFwr_de, DMrd_de, branch_taken_ex,
    input  stall_fd, clr, flush_fd, busy_vec, stall_cnt
  );

  modport slave (
    input  valid_de, rs1_de, rs2_de, rs1_use_de, rs2_use_de,
           rd_de, RFwr_de, DMrd_de, branch_taken_ex,
    output stall_fd, clr, flush_fd, busy_vec, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// Purpose : load-use hazard unit between DE and EX. Each architectural
//           register has a down-counter that is loaded with LOAD_LAT when a
//           load targeting it issues; a DE instruction reading a register
//           whose counter is non-zero is stalled. A taken branch in EX
//           flushes IF/DE and bubbles DE/EX, overriding any stall.
// Ports   : clk      - clock, rising edge
//           rst      - synchronous active-high reset
//           hs       - slave modport of hazard_scoreboard_if
//                      (DE fields in; stall_fd, clr, flush_fd, busy_vec,
//                       stall_cnt out)
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 4,
  parameter int PERF_W   = 16
) (
  input logic                clk,
  input logic                rst,
  hazard_scoreboard_if.slave hs
);
  localparam int NREGS = 2**REG_W;
  localparam logic [CNT_W-1:0] LOAD_SET = CNT_W'(LOAD_LAT);

  logic [CNT_W-1:0]  cnt [NREGS];
  logic [NREGS-1:0]  busy;
  logic [PERF_W-1:0] stall_cnt_q;
  logic              src1_busy;
  logic              src2_busy;
  logic              haz;
  logic              stall;
  logic              issue;

  // x0 is never tracked, so its busy bit is tied low regardless of cnt[0]
  always_comb begin
    busy = '0;
    for (int r = 1; r < NREGS; r++) begin
      busy[r] = (cnt[r] != '0);
    end
  end

  assign src1_busy = hs.rs1_use_de && (hs.rs1_de != '0) && busy[hs.rs1_de];
  assign src2_busy = hs.rs2_use_de && (hs.rs2_de != '0) && busy[hs.rs2_de];
  assign haz       = hs.valid_de && (src1_busy || src2_busy);

  // the flush wins: a wrong-path instruction in DE must not be held
  assign stall = haz && !hs.branch_taken_ex;
  assign issue = hs.valid_de && !stall && !hs.branch_taken_ex;

  assign hs.stall_fd  = !rst && stall;
  assign hs.flush_fd  = !rst && hs.branch_taken_ex;
  assign hs.clr       = !rst && (stall || hs.branch_taken_ex);
  assign hs.busy_vec  = rst ? '0 : busy;
  assign hs.stall_cnt = stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        cnt[r] <= '0;
      end
      stall_cnt_q <= '0;
    end else begin
      cnt[0] <= '0;
      for (int r = 1; r < NREGS; r++) begin
        // a new producer of r replaces whatever is pending on it; an ALU
        // producer is forwarded, so it clears the wait entirely
        if (issue && hs.RFwr_de && (hs.rd_de == REG_W'(r))) begin
          cnt[r] <= hs.DMrd_de ? LOAD_SET : '0;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - CNT_W'(1);
        end
      end
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + PERF_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard
// Drives the same DE stream into two hazard units (LOAD_LAT = 1 with a
// narrow 3-bit stall counter, and LOAD_LAT = 3) and compares both against a
// behavioural model through an expectation queue, plus directed checks.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_W(5), .PERF_W(3))  if1 ();
  hazard_scoreboard_if #(.REG_W(5), .PERF_W(16)) if3 ();

  hazard_scoreboard #(.REG_W(5), .LOAD_LAT(1), .CNT_W(4), .PERF_W(3)) dut1 (
    .clk(clk), .rst(rst), .hs(if1.slave));
  hazard_scoreboard #(.REG_W(5), .LOAD_LAT(3), .CNT_W(4), .PERF_W(16)) dut3 (
    .clk(clk), .rst(rst), .hs(if3.slave));

  typedef struct {
    string       tag;
    int          idx;
    logic        st;
    logic        fl;
    logic        cl;
    logic [31:0] busy;
    logic [31:0] perf;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  int mcnt [2][32];
  int mperf [2];
  int lat  [2] = '{1, 3};
  int pmax [2] = '{7, 65535};

  logic        v, u1, u2, wr, ld, br;
  logic [4:0]  r1, r2, rd;

  logic        last_st [2];
  logic        last_fl [2];
  logic [31:0] last_busy [2];
  logic [31:0] last_perf [2];
  int          seen [2];
  logic [3:0]  pat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [4:0] ir1, input logic iu1,
                       input logic [4:0] ir2, input logic iu2, input logic [4:0] ird,
                       input logic iwr, input logic ild, input logic ibr);
    v = iv; r1 = ir1; u1 = iu1; r2 = ir2; u2 = iu2; rd = ird; wr = iwr; ld = ild; br = ibr;
    if1.valid_de = v; if1.rs1_de = r1; if1.rs1_use_de = u1; if1.rs2_de = r2;
    if1.rs2_use_de = u2; if1.rd_de = rd; if1.RFwr_de = wr; if1.DMrd_de = ld;
    if1.branch_taken_ex = br;
    if3.valid_de = v; if3.rs1_de = r1; if3.rs1_use_de = u1; if3.rs2_de = r2;
    if3.rs2_use_de = u2; if3.rd_de = rd; if3.RFwr_de = wr; if3.DMrd_de = ld;
    if3.branch_taken_ex = br;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic model_out(input int i, output logic st, output logic fl,
                           output logic cl, output logic iss);
    logic haz;
    haz = v && ((u1 && r1 != 0 && mcnt[i][r1] != 0) ||
                (u2 && r2 != 0 && mcnt[i][r2] != 0));
    st  = haz && !br;
    fl  = br;
    cl  = st || br;
    iss = v && !st && !br;
    if (rst) begin
      st = 1'b0; fl = 1'b0; cl = 1'b0;
    end
  endtask

  task automatic get_obs(input int i, output logic st, output logic fl, output logic cl,
                         output logic [31:0] busy, output logic [31:0] perf);
    if (i == 0) begin
      st = if1.stall_fd; fl = if1.flush_fd; cl = if1.clr;
      busy = if1.busy_vec; perf = 32'(if1.stall_cnt);
    end else begin
      st = if3.stall_fd; fl = if3.flush_fd; cl = if3.clr;
      busy = if3.busy_vec; perf = 32'(if3.stall_cnt);
    end
  endtask

  // one clock: push expectations, compare at negedge, advance the model at posedge
  task automatic step(input string tag);
    exp_t        e;
    logic        iss;
    logic        ost, ofl, ocl;
    logic [31:0] obusy, operf;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      e.tag = tag;
      e.idx = i;
      model_out(i, e.st, e.fl, e.cl, iss);
      e.busy = '0;
      if (!rst) begin
        for (int r = 1; r < 32; r++) e.busy[r] = (mcnt[i][r] != 0);
      end
      e.perf = 32'(mperf[i]);
      exp_q.push_back(e);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      get_obs(e.idx, ost, ofl, ocl, obusy, operf);
      check($sformatf("%s L%0d stall_fd", e.tag, lat[e.idx]), 32'(ost), 32'(e.st));
      check($sformatf("%s L%0d flush_fd", e.tag, lat[e.idx]), 32'(ofl), 32'(e.fl));
      check($sformatf("%s L%0d clr", e.tag, lat[e.idx]), 32'(ocl), 32'(e.cl));
      check($sformatf("%s L%0d busy_vec", e.tag, lat[e.idx]), obusy, e.busy);
      check($sformatf("%s L%0d stall_cnt", e.tag, lat[e.idx]), operf, e.perf);
      last_st[e.idx]   = ost;
      last_fl[e.idx]   = ofl;
      last_busy[e.idx] = obusy;
      last_perf[e.idx] = operf;
      if (ost === 1'b1) seen[e.idx]++;
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        for (int r = 0; r < 32; r++) mcnt[i][r] = 0;
        mperf[i] = 0;
      end else begin
        logic st, fl, cl;
        model_out(i, st, fl, cl, iss);
        for (int r = 1; r < 32; r++) begin
          if (iss && wr && rd == 5'(r)) mcnt[i][r] = ld ? lat[i] : 0;
          else if (mcnt[i][r] != 0)     mcnt[i][r] = mcnt[i][r] - 1;
        end
        if (st && mperf[i] < pmax[i]) mperf[i] = mperf[i] + 1;
      end
    end
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    step("reset");
    step("reset");
    rst = 1'b0;
    step("idle");
    check("reset stall_cnt L1", last_perf[0], 32'd0);
    check("reset busy_vec L3", last_busy[1], 32'd0);

    // load x5, dependent reads rs1 = 5
    drive(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 0);
    step("ld x5");
    seen = '{0, 0};
    pat  = '0;
    drive(1, 5'd5, 1, 5'd0, 0, 5'd10, 1, 0, 0);
    repeat (4) begin
      step("use x5");
      pat = {pat[2:0], last_busy[1][5]};
    end
    check("x5 stall cycles L1", 32'(seen[0]), 32'd1);
    check("x5 stall cycles L3", 32'(seen[1]), 32'd3);
    check("x5 busy seq L3", 32'(pat), 32'b1110);

    // load x2, dependent reads rs2 = 2
    drive(1, 5'd0, 0, 5'd0, 0, 5'd2, 1, 1, 0);
    step("ld x2");
    seen = '{0, 0};
    drive(1, 5'd0, 0, 5'd2, 1, 5'd10, 1, 0, 0);
    repeat (4) step("use x2");
    check("x2 stall cycles L1", 32'(seen[0]), 32'd1);
    check("x2 stall cycles L3", 32'(seen[1]), 32'd3);
    check("stall_cnt after two L1", last_perf[0], 32'd2);
    check("stall_cnt after two L3", last_perf[1], 32'd6);

    // WAW: ALU write of x3 after a load of x3 clears the wait
    drive(1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 1, 0);
    step("ld x3");
    drive(1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 0, 0);
    step("alu x3");
    drive(1, 5'd3, 1, 5'd3, 1, 5'd11, 1, 0, 0);
    step("use x3");
    check("waw no stall L1", 32'(last_st[0]), 32'd0);
    check("waw no stall L3", 32'(last_st[1]), 32'd0);

    // pending stall meets a taken branch; wrong-path load to x9 is dropped
    drive(1, 5'd0, 0, 5'd0, 0, 5'd2, 1, 1, 0);
    step("ld x2 b");
    drive(1, 5'd2, 1, 5'd0, 0, 5'd9, 1, 1, 1);
    step("branch");
    check("branch no stall L1", 32'(last_st[0]), 32'd0);
    check("branch flush L3", 32'(last_fl[1]), 32'd1);
    idle();
    step("post br");
    check("wrong-path x9 L1", 32'(last_busy[0][9]), 32'd0);
    check("wrong-path x9 L3", 32'(last_busy[1][9]), 32'd0);
    check("x2 keeps counting L3", 32'(last_busy[1][2]), 32'd1);
    repeat (3) step("drain");

    // x0 never tracked / never stalls; unused or invalid sources never stall
    drive(1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 1, 0);
    step("ld x0");
    drive(1, 5'd0, 1, 5'd0, 1, 5'd12, 1, 0, 0);
    step("use x0");
    check("x0 no stall L3", 32'(last_st[1]), 32'd0);
    check("x0 not busy L3", last_busy[1], 32'd0);
    drive(1, 5'd0, 0, 5'd0, 0, 5'd4, 1, 1, 0);
    step("ld x4");
    drive(1, 5'd4, 0, 5'd4, 0, 5'd13, 1, 0, 0);
    step("x4 unused");
    check("unused src no stall L3", 32'(last_st[1]), 32'd0);
    drive(0, 5'd4, 1, 5'd4, 1, 5'd13, 1, 0, 0);
    step("x4 invalid");
    check("invalid no stall L3", 32'(last_st[1]), 32'd0);
    idle();
    repeat (3) step("drain");

    // drive the 3-bit counter of the LOAD_LAT=1 unit into saturation
    repeat (10) begin
      drive(1, 5'd0, 0, 5'd0, 0, 5'd6, 1, 1, 0);
      step("ld x6");
      drive(1, 5'd6, 1, 5'd0, 0, 5'd14, 1, 0, 0);
      repeat (2) step("use x6");
    end
    idle();
    step("sat");
    check("stall_cnt saturates L1", last_perf[0], 32'd7);

    // reset in the middle of a pending load
    drive(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 1, 0);
    step("ld x7");
    idle();
    step("x7 pending");
    check("x7 pending L3", 32'(last_busy[1][7]), 32'd1);
    rst = 1'b1;
    step("mid rst");
    rst = 1'b0;
    drive(1, 5'd7, 1, 5'd0, 0, 5'd15, 1, 0, 0);
    step("use x7");
    check("after rst no stall L3", 32'(last_st[1]), 32'd0);
    check("after rst busy L3", last_busy[1], 32'd0);
    check("after rst stall_cnt L1", last_perf[0], 32'd0);
    check("after rst stall_cnt L3", last_perf[1], 32'd0);
    idle();
    step("end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
